data_mem_lsu: RTL

- Parametrised successor to the CPU byte-addressed data memory.
- Word-organised RAM with four byte lanes, fronted by a valid/ready request port and a pipelined response port.
- Handles SB/SH/SW stores and LB/LH/LW/LBU/LHU loads, with sign/zero extension and misalignment error reporting.
- Clears the RAM with a sequential one-word-per-cycle sweep. Sits between the CPU MEM stage and the data RAM.

---
 rtl/data_mem_lsu_if.sv | 37 +++
 rtl/data_mem_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu_if.sv
// -----------------------------------------------------------------------------
// data_mem_lsu_if
// Request/response bundle between the CPU MEM stage (master) and the data
// memory load/store unit (slave).
//   i_req_valid / o_req_ready : request handshake, accepted on valid && ready
//   i_req_we, i_req_addr, i_req_size, i_req_unsigned, i_req_wdata : request
//   o_rsp_valid, o_rsp_rdata, o_rsp_err : in-order response, no backpressure
//   i_clr / o_busy : RAM clear sweep request and status
// -----------------------------------------------------------------------------
interface data_mem_lsu_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [1:0]            i_req_size;
  logic                  i_req_unsigned;
  logic [31:0]           i_req_wdata;
  logic                  o_rsp_valid;
  logic [31:0]           o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  i_clr;
  logic                  o_busy;

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned,
           i_req_wdata, i_clr,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned,
           i_req_wdata, i_clr,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy
  );
endinterface

// File: rtl/data_mem_lsu.sv
// -----------------------------------------------------------------------------
// data_mem_lsu
// Word-organised data RAM (four byte lanes) behind a valid/ready request port
// with a fixed-latency, in-order response port. Handles SB/SH/SW stores and
// LB/LH/LW/LBU/LHU loads, flags misaligned or reserved-size requests, and
// zeroes the whole RAM with a one-word-per-cycle sweep after reset or i_clr.
// Ports:
//   clk   : clock
//   i_rst : synchronous, active-high reset
//   bus   : data_mem_lsu_if slave (request, response, clear/busy)
// Parameters:
//   ADDR_WIDTH   : byte-address width, RAM depth 2**(ADDR_WIDTH-2) words
//   READ_LATENCY : accept edge to o_rsp_valid, legal range 1..4
//
//   state | meaning
//   CLEAR | zeroing word cnt_q this cycle, requests stalled, busy
//   IDLE  | accepting requests, i_clr starts a new sweep
// -----------------------------------------------------------------------------
module data_mem_lsu #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input logic           clk,
  input logic           i_rst,
  data_mem_lsu_if.slave bus
);
  localparam int WIDX  = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WIDX;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [WIDX-1:0] cnt_q, cnt_d;

  logic [31:0] mem_q [DEPTH];

  logic            accept;
  logic            req_err;
  logic [WIDX-1:0] req_idx;
  logic [1:0]      req_lane;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.o_req_ready = 1'b0;
    bus.o_busy      = 1'b1;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WIDX'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        bus.o_req_ready = 1'b1;
        bus.o_busy      = 1'b0;
        if (bus.i_clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign accept   = bus.i_req_valid && bus.o_req_ready;
  assign req_idx  = bus.i_req_addr[ADDR_WIDTH-1:2];
  assign req_lane = bus.i_req_addr[1:0];

  // Store data is replicated across lanes so the byte enables alone pick
  // which lanes are written.
  always_comb begin
    req_err = 1'b0;
    wr_be   = 4'b0000;
    wr_data = bus.i_req_wdata;
    case (bus.i_req_size)
      2'b00: begin
        wr_be   = 4'b0001 << req_lane;
        wr_data = {4{bus.i_req_wdata[7:0]}};
      end
      2'b01: begin
        req_err = req_lane[0];
        wr_be   = req_lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.i_req_wdata[15:0]}};
      end
      2'b10: begin
        req_err = (req_lane != 2'b00);
        wr_be   = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
  end

  // Requests are only accepted in IDLE, so the sweep and stores never collide.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && bus.i_req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  logic        s1_valid_q;
  logic [31:0] s1_word_q;
  logic [1:0]  s1_lane_q;
  logic [1:0]  s1_size_q;
  logic        s1_uns_q;
  logic        s1_err_q;
  logic        s1_we_q;

  always_ff @(posedge clk) begin
    if (i_rst) s1_valid_q <= 1'b0;
    else       s1_valid_q <= accept;
  end

  // The word read here sees every store committed on earlier edges, which
  // gives read-after-write for back-to-back store/load pairs.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_word_q <= mem_q[req_idx];
      s1_lane_q <= req_lane;
      s1_size_q <= bus.i_req_size;
      s1_uns_q  <= bus.i_req_unsigned;
      s1_err_q  <= req_err;
      s1_we_q   <= bus.i_req_we;
    end
  end

  logic [7:0]  s1_byte;
  logic [15:0] s1_half;
  logic [31:0] s1_rdata;

  always_comb begin
    s1_byte  = s1_word_q[{s1_lane_q, 3'b000} +: 8];
    s1_half  = s1_lane_q[1] ? s1_word_q[31:16] : s1_word_q[15:0];
    s1_rdata = '0;
    if (!s1_err_q && !s1_we_q) begin
      case (s1_size_q)
        2'b00:   s1_rdata = s1_uns_q ? {24'b0, s1_byte} : {{24{s1_byte[7]}}, s1_byte};
        2'b01:   s1_rdata = s1_uns_q ? {16'b0, s1_half} : {{16{s1_half[15]}}, s1_half};
        default: s1_rdata = s1_word_q;
      endcase
    end
  end

  logic        fin_valid;
  logic [31:0] fin_rdata;
  logic        fin_err;

  if (READ_LATENCY <= 1) begin : g_lat1
    assign fin_valid = s1_valid_q;
    assign fin_rdata = s1_rdata;
    assign fin_err   = s1_err_q;
  end else begin : g_latn
    localparam int N = READ_LATENCY - 1;
    logic [N-1:0] v_q;
    logic [N-1:0] e_q;
    logic [31:0]  d_q [N];

    always_ff @(posedge clk) begin
      if (i_rst) begin
        v_q <= '0;
      end else begin
        v_q[0] <= s1_valid_q;
        for (int i = 1; i < N; i++) v_q[i] <= v_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      d_q[0] <= s1_rdata;
      e_q[0] <= s1_err_q;
      for (int i = 1; i < N; i++) begin
        d_q[i] <= d_q[i-1];
        e_q[i] <= e_q[i-1];
      end
    end

    assign fin_valid = v_q[N-1];
    assign fin_rdata = d_q[N-1];
    assign fin_err   = e_q[N-1];
  end

  // Last response is held so rdata/err stay stable between strobes.
  logic [31:0] rdata_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (fin_valid) begin
      rdata_q <= fin_rdata;
      err_q   <= fin_err;
    end
  end

  assign bus.o_rsp_valid = fin_valid;
  assign bus.o_rsp_rdata = fin_valid ? fin_rdata : rdata_q;
  assign bus.o_rsp_err   = fin_valid ? fin_err   : err_q;
endmodule
